// File: rtl/mlp_multiclass_seq.sv
// Sequential MLP classifier: P binary pixels -> C classes on one shared MAC, optional output-layer perceptron update.
// Latency: N*(P+1) + C*(N+1) + 1 cycles from the accepting edge to done; N+1 more when an update runs.
// Backpressure: none; start is accepted only in IDLE and ignored while busy and in the done cycle.
module mlp_multiclass_seq #(
  parameter  int P        = 16,
  parameter  int N        = 8,
  parameter  int C        = 2,
  parameter  int W        = 8,
  parameter  int FRAC     = 6,
  parameter  int LR_SHIFT = 2,
  localparam int CW       = (C > 2) ? $clog2(C) : 1,
  localparam int SW       = W + $clog2(N + 1) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [P-1:0]         x,
  input  logic                 learn,
  input  logic [CW-1:0]        label,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        class_out,
  output logic signed [SW-1:0] score_max,
  output logic [15:0]          err_cnt
);

  localparam int HW  = W + $clog2(P + 1) + 1;
  // Output accumulator holds bias<<FRAC plus N products of (W-1)-bit h and W-bit weights.
  localparam int OW  = 2 * W + $clog2(N + 1) + 1;
  localparam int PW  = (P > 1) ? $clog2(P) : 1;
  localparam int NW  = (N > 1) ? $clog2(N) : 1;
  localparam int MX  = (P > N) ? P : N;
  localparam int KW  = $clog2(MX + 1);
  localparam int IMX = (N > C) ? N : C;
  localparam int IW  = (IMX > 1) ? $clog2(IMX) : 1;

  localparam logic [KW-1:0]        K_P   = KW'(P);
  localparam logic [KW-1:0]        K_N   = KW'(N);
  localparam logic [IW-1:0]        I_NL  = IW'(N - 1);
  localparam logic [IW-1:0]        I_CL  = IW'(C - 1);
  localparam logic [CW:0]          C_LIM = (CW + 1)'(C);
  localparam logic signed [HW-1:0] WH_POS = HW'(1 << (FRAC - 2));
  localparam logic signed [HW-1:0] WH_NEG = -WH_POS;
  localparam logic signed [HW-1:0] H_MAX  = {{(HW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [OW-1:0] S_MAX  = {{(OW - SW + 1){1'b0}}, {(SW - 1){1'b1}}};
  localparam logic signed [OW-1:0] S_MIN  = ~S_MAX;
  localparam logic signed [SW-1:0] SAT_HI = {1'b0, {(SW - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {1'b1, {(SW - 1){1'b0}}};
  localparam logic [W:0]           DB     = (W + 1)'((1 << FRAC) >> LR_SHIFT);

  // Hidden weights are fixed at their reset pattern forever, so they live as a constant sign map.
  function automatic logic [N*P-1:0] wh_sign_init();
    logic [N*P-1:0] r;
    logic           b;
    r = '0;
    for (int k = N * P - 1; k >= 0; k--) begin
      b = (((k * 5) % 7) < 3);
      r = {r[N*P-2:0], b};
    end
    return r;
  endfunction

  localparam logic [N-1:0][P-1:0] WH_SIGN = wh_sign_init();

  function automatic logic signed [W-1:0] sat_w(input logic [W:0] v);
    if (v[W] != v[W-1]) return v[W] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
    return v[W-1:0];
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_HID, S_OUT, S_UPD, S_DONE} state_t;

  state_t                 state;
  logic [KW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [P-1:0]           x_r;
  logic                   learn_r;
  logic [CW-1:0]          lab_r;
  logic signed [HW-1:0]   acc_h;
  logic signed [OW-1:0]   acc_o;
  logic signed [SW-1:0]   best_s;
  logic [CW-1:0]          best_c;
  logic [W-2:0]           h   [N];
  logic signed [W-1:0]    w_o [C][N];
  logic signed [W-1:0]    b_o [C];

  logic [PW-1:0]          p_sel;
  logic [NW-1:0]          j_sel, u_sel, n_sel;
  logic [CW-1:0]          c_sel;
  logic signed [HW-1:0]   hid_add, acc_h_nxt;
  logic [W-2:0]           h_clip, h_sel, h_u;
  logic signed [W-1:0]    w_sel, b_sel, w_lab, w_prd, b_lab, b_prd;
  logic signed [OW-1:0]   h_ext, w_ext, prod, bias_ext, acc_o_nxt, s_shift;
  logic signed [SW-1:0]   s_sat, best_s_nxt;
  logic [CW-1:0]          best_c_nxt;
  logic                   better;
  logic [W:0]             dh;
  logic signed [W-1:0]    w_lab_nxt, w_prd_nxt, b_lab_nxt, b_prd_nxt;

  // Shared MAC datapath: hidden accumulate/clip, output MAC/scale/argmax, and saturating update values.
  always_comb begin
    p_sel = PW'(cnt - KW'(1));
    j_sel = NW'(cnt - KW'(1));
    u_sel = NW'(cnt);
    n_sel = NW'(idx);
    c_sel = CW'(idx);

    // Hidden biases reset to zero and are never trained, so neuron cycle 0 just clears acc.
    hid_add = '0;
    if (x_r[p_sel]) hid_add = WH_SIGN[n_sel][p_sel] ? WH_POS : WH_NEG;
    acc_h_nxt = (cnt == '0) ? '0 : acc_h + hid_add;
    if (acc_h_nxt[HW-1])        h_clip = '0;
    else if (acc_h_nxt > H_MAX) h_clip = '1;
    else                        h_clip = acc_h_nxt[W-2:0];

    h_sel     = h[j_sel];
    w_sel     = w_o[c_sel][j_sel];
    b_sel     = b_o[c_sel];
    h_ext     = {{(OW - W + 1){1'b0}}, h_sel};
    w_ext     = {{(OW - W){w_sel[W-1]}}, w_sel};
    prod      = h_ext * w_ext;
    bias_ext  = {{(OW - W){b_sel[W-1]}}, b_sel} << FRAC;
    acc_o_nxt = (cnt == '0) ? bias_ext : acc_o + prod;
    s_shift   = acc_o_nxt >>> FRAC;
    if (s_shift > S_MAX)      s_sat = SAT_HI;
    else if (s_shift < S_MIN) s_sat = SAT_LO;
    else                      s_sat = s_shift[SW-1:0];
    // Strict greater-than keeps the lowest index on ties; class 0 always seeds the running max.
    better     = (idx == '0) || (s_sat > best_s);
    best_s_nxt = better ? s_sat : best_s;
    best_c_nxt = better ? c_sel : best_c;

    h_u       = h[u_sel];
    dh        = {2'b00, h_u} >> LR_SHIFT;
    w_lab     = w_o[lab_r][u_sel];
    w_prd     = w_o[best_c][u_sel];
    b_lab     = b_o[lab_r];
    b_prd     = b_o[best_c];
    w_lab_nxt = sat_w({w_lab[W-1], w_lab} + dh);
    w_prd_nxt = sat_w({w_prd[W-1], w_prd} - dh);
    b_lab_nxt = sat_w({b_lab[W-1], b_lab} + DB);
    b_prd_nxt = sat_w({b_prd[W-1], b_prd} - DB);
  end

  // Sequencer FSM with registered handshake/result outputs and output-layer parameter storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      x_r       <= '0;
      learn_r   <= 1'b0;
      lab_r     <= '0;
      acc_h     <= '0;
      acc_o     <= '0;
      best_s    <= '0;
      best_c    <= '0;
      h         <= '{default: '0};
      w_o       <= '{default: '0};
      b_o       <= '{default: '0};
      busy      <= 1'b0;
      done      <= 1'b0;
      class_out <= '0;
      score_max <= '0;
      err_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_r     <= x;
            learn_r <= learn;
            lab_r   <= ({1'b0, label} >= C_LIM) ? '0 : label;
            cnt     <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_HID;
          end
        end
        S_HID: begin
          acc_h <= acc_h_nxt;
          if (cnt == K_P) begin
            h[n_sel] <= h_clip;
            cnt      <= '0;
            if (idx == I_NL) begin
              idx   <= '0;
              state <= S_OUT;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + KW'(1);
          end
        end
        S_OUT: begin
          acc_o <= acc_o_nxt;
          if (cnt == K_N) begin
            best_s <= best_s_nxt;
            best_c <= best_c_nxt;
            cnt    <= '0;
            if (idx == I_CL) begin
              idx <= '0;
              if (learn_r && (best_c_nxt != lab_r)) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                state <= S_UPD;
              end else begin
                done      <= 1'b1;
                busy      <= 1'b0;
                class_out <= best_c_nxt;
                score_max <= best_s_nxt;
                state     <= S_DONE;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + KW'(1);
          end
        end
        S_UPD: begin
          // label != pred here, so the two writes always hit different rows.
          if (cnt == K_N) begin
            b_o[lab_r]  <= b_lab_nxt;
            b_o[best_c] <= b_prd_nxt;
            cnt         <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
            class_out   <= best_c;
            score_max   <= best_s;
            state       <= S_DONE;
          end else begin
            w_o[lab_r][u_sel]  <= w_lab_nxt;
            w_o[best_c][u_sel] <= w_prd_nxt;
            cnt                <= cnt + KW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_multiclass_seq.sv
// Bench for mlp_multiclass_seq: directed steps plus random runs against an arithmetic reference model.
// Latency: checks done timing from the accepting edge for inference and learning runs.
// Backpressure: probes start while busy, in the done cycle, and reset mid-run.
module tb_mlp_multiclass_seq;

  localparam int P = 16, N = 8, C = 2, W = 8, FRAC = 6, LR_SHIFT = 2;
  localparam int CW = (C > 2) ? $clog2(C) : 1;
  localparam int SW = W + $clog2(N + 1) + 2;
  localparam int WMAX = (1 << (W - 1)) - 1;
  localparam int WMIN = -(1 << (W - 1));
  localparam int SMAX = (1 << (SW - 1)) - 1;
  localparam int SMIN = -(1 << (SW - 1));

  logic                 clk = 1'b0;
  logic                 rst, start, learn;
  logic [P-1:0]         x;
  logic [CW-1:0]        label;
  logic                 busy, done;
  logic [CW-1:0]        class_out;
  logic signed [SW-1:0] score_max;
  logic [15:0]          err_cnt;

  int errors = 0;
  int checks = 0;
  int m_wo[C][N];
  int m_bo[C];
  int m_err;
  int e_cls, e_score, e_lat;
  int prev_cls;

  always #5 clk = ~clk;

  mlp_multiclass_seq #(.P(P), .N(N), .C(C), .W(W), .FRAC(FRAC), .LR_SHIFT(LR_SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .learn(learn), .label(label),
    .busy(busy), .done(done), .class_out(class_out), .score_max(score_max), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int wh(input int n, input int p);
    return ((((n * P + p) * 5) % 7) < 3) ? (1 << (FRAC - 2)) : -(1 << (FRAC - 2));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      m_bo[c] = 0;
      for (int j = 0; j < N; j++) m_wo[c][j] = 0;
    end
    m_err = 0;
  endtask

  // Scores a pattern with the current model weights, then applies the learning rule if needed.
  task automatic model_run(input logic [P-1:0] xv, input logic lv, input int lab_in);
    int hv[N];
    int acc, s, best, bc, lab, d;
    lab = (lab_in >= C) ? 0 : lab_in;
    for (int n = 0; n < N; n++) begin
      acc = 0;
      for (int p = 0; p < P; p++) if (xv[p]) acc += wh(n, p);
      hv[n] = sat(acc, 0, WMAX);
    end
    best = 0;
    bc = 0;
    for (int c = 0; c < C; c++) begin
      acc = m_bo[c] * (1 << FRAC);
      for (int j = 0; j < N; j++) acc += hv[j] * m_wo[c][j];
      s = sat(acc >>> FRAC, SMIN, SMAX);
      if (c == 0 || s > best) begin
        best = s;
        bc = c;
      end
    end
    e_cls = bc;
    e_score = best;
    e_lat = N * (P + 1) + C * (N + 1) + 1;
    if (lv && bc != lab) begin
      m_err = (m_err < 65535) ? m_err + 1 : 65535;
      e_lat += N + 1;
      for (int j = 0; j < N; j++) begin
        d = hv[j] >> LR_SHIFT;
        m_wo[lab][j] = sat(m_wo[lab][j] + d, WMIN, WMAX);
        m_wo[bc][j]  = sat(m_wo[bc][j] - d, WMIN, WMAX);
      end
      d = (1 << FRAC) >> LR_SHIFT;
      m_bo[lab] = sat(m_bo[lab] + d, WMIN, WMAX);
      m_bo[bc]  = sat(m_bo[bc] - d, WMIN, WMAX);
    end
  endtask

  task automatic run(input string tag, input logic [P-1:0] xv, input logic lv, input logic [CW-1:0] lab,
                     input int poke_a, input int poke_b, input int rst_at);
    int cyc;
    if (rst_at == 0) model_run(xv, lv, int'(lab));
    @(negedge clk);
    x = xv; learn = lv; label = lab; start = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the run must use the latched values.
    start = 1'b0; x = ~xv; learn = ~lv; label = ~lab;
    cyc = 1;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    while (done !== 1'b1 && cyc < 400 && (rst_at == 0 || cyc < rst_at)) begin
      if (cyc == 50) chk({tag, "_hold"}, 64'(class_out), 64'(prev_cls));
      start = (cyc == poke_a || cyc == poke_b);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (rst_at != 0) begin
      chk({tag, "_nodone"}, 64'(done), 64'(0));
      return;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(e_lat));
    chk({tag, "_class"}, 64'(class_out), 64'(e_cls));
    chk({tag, "_score"}, 64'(score_max), 64'(e_score));
    chk({tag, "_err"}, 64'(err_cnt), 64'(m_err));
    prev_cls = e_cls;
    // A start offered in the done cycle must be ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_idle"}, 64'({busy, done}), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_class"}, 64'(class_out), 64'(0));
    chk({tag, "_score"}, 64'(score_max), 64'(0));
    chk({tag, "_err"}, 64'(err_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_post"}, 64'({busy, done}), 64'(0));
    model_reset();
    prev_cls = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; learn = 1'b0; x = '0; label = '0;
    model_reset();
    prev_cls = 0;
    do_reset("rst0");

    run("zero_w", 16'hFFFF, 1'b0, CW'(1), 0, 0, 0);
    run("learn1", 16'hFFFF, 1'b1, CW'(1), 0, 0, 0);
    run("after", 16'hFFFF, 1'b0, CW'(0), 0, 0, 0);
    chk("after_pos", 64'($signed(score_max) > 0), 64'(1));
    run("correct", 16'hFFFF, 1'b1, CW'(1), 0, 0, 0);
    run("poke", 16'h0F0F, 1'b0, CW'(0), 10, 100, 0);

    for (int i = 0; i < 16; i++)
      run("rand", P'($urandom), 1'($urandom_range(0, 1)), CW'($urandom_range(0, C - 1)), 0, 0, 0);

    run("abort", 16'h00FF, 1'b1, CW'(0), 0, 0, 140);
    do_reset("rst1");
    run("post_rst", 16'hFFFF, 1'b0, CW'(0), 0, 0, 0);
    chk("post_rst_w", 64'(score_max), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mlp_multiclass_seq.md
Name: mlp_multiclass_seq

Overview:
- Time-multiplexed, parametrised successor to the O/X MLP classifier.
- Classifies a P-pixel binary pattern into one of C classes using a single shared MAC engine, sequenced by an FSM.
- Optional on-line learning: perceptron-style update of the output layer when the prediction is wrong.
- Sits between the pixel-capture front end and the display/result logic; uses a start/busy/done handshake instead of combinational scoring.

Parameters:
- P, 16: number of binary input pixels.
- N, 8: hidden neurons.
- C, 2: output classes (C >= 2).
- W, 8: signed weight/bias width.
- FRAC, 6: fractional bits of weights, biases and activations.
- LR_SHIFT, 2: learning-rate right shift.
- Derived: CW = max(1, clog2(C)); HW = W + clog2(P+1) + 1; SW = W + clog2(N+1) + 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- x  in  P  input pattern, sampled on the accepted start.
- learn  in  1  enable update, sampled with start.
- label  in  CW  true class, sampled with start; values >= C are treated as 0.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- class_out  out  CW  argmax class, held until the next done.
- score_max  out  SW  signed winning score (Q FRAC), held.
- err_cnt  out  16  mispredictions during learn runs; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; busy=0, done=0, class_out=0, score_max=0, err_cnt=0.
  - b_h = 0, w_o = 0, b_o = 0.
  - w_h[n][p] = +2^(FRAC-2) if ((n*P+p)*5 mod 7) < 3, else -2^(FRAC-2).
  - A reset mid-run aborts the run: no done, no weight update, no err_cnt change.
- FSM states: IDLE -> HID -> OUT -> (UPD) -> DONE -> IDLE.
- IDLE: on start=1, latch x, learn and label, then go to HID. start while busy is ignored.
- HID: N*(P+1) cycles; per neuron n:
  - Cycle 0: acc = sign-extended b_h[n].
  - Cycles 1..P: acc += w_h[n][p] if x[p]=1.
  - End of neuron: h[n] = clip(acc, 0, 2^(W-1)-1) (ReLU plus saturation), stored as unsigned W-1 bits.
- OUT: C*(N+1) cycles; per class c:
  - Cycle 0: acc = b_o[c] <<< FRAC.
  - Cycles 1..N: acc += h[j] * w_o[c][j].
  - End of class: s[c] = acc >>> FRAC, width SW, saturating.
  - Running argmax uses strict greater-than, so ties go to the lowest index.
- After OUT:
  - If learn=1 and pred != label: err_cnt++ (saturating), then go to UPD.
  - Otherwise go directly to DONE.
- UPD: N+1 cycles.
  - Cycle j < N: w_o[label][j] += h[j] >>> LR_SHIFT and w_o[pred][j] -= h[j] >>> LR_SHIFT.
  - Cycle N: b_o[label] += 2^FRAC >>> LR_SHIFT and b_o[pred] -= 2^FRAC >>> LR_SHIFT.
  - All results saturate to W-bit signed [-2^(W-1), 2^(W-1)-1]; no wrap.
  - Hidden weights are never modified.
- DONE: one cycle; done=1, class_out and score_max registered, busy=0 in the same cycle; next state IDLE.
- Latency from the accepting edge to the done cycle:
  - L0 = N*(P+1) + C*(N+1) + 1.
  - L0 + N + 1 when an update runs.
  - Defaults: L0 = 155; 164 with update.
- A start in the DONE cycle is ignored. A back-to-back start is accepted on the following IDLE cycle.

Test Plan:
- Reset values: assert rst for 3 cycles -> busy=0, done=0, class_out=0, score_max=0, err_cnt=0. Release rst -> still idle, no done.
- Zero output weights: start, x=16'hFFFF, learn=0 -> single done exactly 155 cycles after the accepting edge; class_out=0 (tie), score_max=0, err_cnt=0.
- Learning: same x, learn=1, label=1 -> done at 164; class_out=0 (pre-update prediction), err_cnt=1. Rerun with learn=0 -> done at 155, class_out=1, score_max > 0 (bias alone contributes +16 raw = 0.25).
- No update on correct prediction: repeat learn=1, label=1 -> done at 155 (no UPD), err_cnt stays 1.
- start ignored while busy: pulse start at cycles 10 and 100 of a run -> exactly one done; next run begins only after a start in IDLE.
- Reset mid-run: rst asserted at cycle 140 of a learn run -> no done. Post-reset inference x=16'hFFFF -> class_out=0, score_max=0 (weights back to reset values), err_cnt=0.
